seven_segments_pattern_decoder: RTL

SEVEN_SEGMENTS_PATTERN_DECODER -- requirements
Module: seven_segments_pattern_decoder

---
 rtl/seven_segments_pattern_decoder.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/seven_segments_pattern_decoder.sv
// rtl/seven_segments_pattern_decoder.sv - debounced seven-segment scan decoder with event queue slot
// Optional feature macro: SEVEN_SEGMENTS_DASH_EN (accept "-" as a blank digit).
module seven_segments_pattern_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  segmentInput,
    input  logic [3:0]  digitSelect,
    output logic [15:0] digitValues,
    output logic [3:0]  digitValid,
    output logic        outValid,
    input  logic        outReady,
    output logic [1:0]  outDigit,
    output logic [3:0]  outNibble,
    output logic        errorPulse,
    output logic        overflowFlag
);

    localparam logic [7:0] LP_STABLE = 8'(STABLE_CYCLES);
    localparam logic [6:0] LP_DASH   = 7'b0111111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILTER = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_count;
    logic [7:0]  w_count_next;
    logic [10:0] r_capture;
    logic [10:0] w_capture_next;
    logic        w_accept;

    logic [10:0] w_sample;
    logic        w_onehot;
    logic        w_same;
    logic [1:0]  w_digit;
    logic        w_legal;
    logic [3:0]  w_nibble;
    logic        w_dash;
    logic        w_handshake;
    logic        w_slot_free;

    logic [15:0] r_digit_values;
    logic [3:0]  r_digit_valid;
    logic        r_out_valid;
    logic [1:0]  r_out_digit;
    logic [3:0]  r_out_nibble;
    logic        r_error_pulse;
    logic        r_overflow;

    assign w_sample = {digitSelect, segmentInput};
    assign w_onehot = (digitSelect != 4'd0) && ((digitSelect & (digitSelect - 4'd1)) == 4'd0);
    assign w_same   = (w_sample == r_capture);
    assign w_dash   = (segmentInput == LP_DASH);

    always_comb begin
        w_digit = 2'd0;
        case (digitSelect)
            4'b0010: w_digit = 2'd1;
            4'b0100: w_digit = 2'd2;
            4'b1000: w_digit = 2'd3;
            default: w_digit = 2'd0;
        endcase
    end

    // Active-low segments, bit6=g .. bit0=a.
    always_comb begin
        w_legal  = 1'b1;
        w_nibble = 4'h0;
        case (segmentInput)
            7'b1000000: w_nibble = 4'h0;
            7'b1111001: w_nibble = 4'h1;
            7'b0100100: w_nibble = 4'h2;
            7'b0110000: w_nibble = 4'h3;
            7'b0011001: w_nibble = 4'h4;
            7'b0010010: w_nibble = 4'h5;
            7'b0000010: w_nibble = 4'h6;
            7'b1111000: w_nibble = 4'h7;
            7'b0000000: w_nibble = 4'h8;
            7'b0010000: w_nibble = 4'h9;
            7'b0001000: w_nibble = 4'hA;
            7'b0000011: w_nibble = 4'hB;
            7'b1000110: w_nibble = 4'hC;
            7'b0100001: w_nibble = 4'hD;
            7'b0000110: w_nibble = 4'hE;
            7'b0001110: w_nibble = 4'hF;
            default:    w_legal  = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= 8'd0;
            r_capture <= 11'd0;
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            r_capture <= w_capture_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_count_next   = r_count;
        w_capture_next = r_capture;
        w_accept       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_onehot) begin
                    w_capture_next = w_sample;
                    w_count_next   = 8'd1;
                    w_state_next   = S_FILTER;
                end else begin
                    w_count_next   = 8'd0;
                end
            end
            S_FILTER: begin
                if (!w_onehot) begin
                    w_count_next = 8'd0;
                    w_state_next = S_IDLE;
                end else if (w_same) begin
                    w_count_next = r_count + 8'd1;
                end else begin
                    w_capture_next = w_sample;
                    w_count_next   = 8'd1;
                end
            end
            S_HOLD: begin
                if (!w_onehot) begin
                    w_count_next = 8'd0;
                    w_state_next = S_IDLE;
                end else if (!w_same) begin
                    w_capture_next = w_sample;
                    w_count_next   = 8'd1;
                    w_state_next   = S_FILTER;
                end
            end
            default: begin
                w_count_next = 8'd0;
                w_state_next = S_IDLE;
            end
        endcase
        // Any path that lands in FILTER with a full run accepts, which also covers STABLE_CYCLES=1.
        if ((w_state_next == S_FILTER) && (w_count_next == LP_STABLE)) begin
            w_accept     = 1'b1;
            w_state_next = S_HOLD;
        end
    end

    assign w_handshake = r_out_valid && outReady;
    assign w_slot_free = !r_out_valid || outReady;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_digit_values <= 16'd0;
            r_digit_valid  <= 4'd0;
            r_out_valid    <= 1'b0;
            r_out_digit    <= 2'd0;
            r_out_nibble   <= 4'd0;
            r_error_pulse  <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            r_error_pulse <= 1'b0;
            if (w_handshake) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                if (w_legal) begin
                    r_digit_values[w_digit*4 +: 4] <= w_nibble;
                    r_digit_valid[w_digit]         <= 1'b1;
                    if (w_slot_free) begin
                        r_out_valid  <= 1'b1;
                        r_out_digit  <= w_digit;
                        r_out_nibble <= w_nibble;
                    end else begin
                        r_overflow <= 1'b1;
                    end
                end else begin
                    r_digit_valid[w_digit] <= 1'b0;
`ifdef SEVEN_SEGMENTS_DASH_EN
                    r_error_pulse <= !w_dash;
`else
                    r_error_pulse <= 1'b1;
`endif
                end
            end
        end
    end

`ifndef SEVEN_SEGMENTS_DASH_EN
    logic w_unused_dash;
    assign w_unused_dash = w_dash;
`endif

    assign digitValues  = r_digit_values;
    assign digitValid   = r_digit_valid;
    assign outValid     = r_out_valid;
    assign outDigit     = r_out_digit;
    assign outNibble    = r_out_nibble;
    assign errorPulse   = r_error_pulse;
    assign overflowFlag = r_overflow;

endmodule
